// File: rtl/axis_sync_fifo.sv
// Synchronous AXI4-Stream FIFO with registered s_tready/m_tvalid, fill level and stored-packet count.
// Define AXIS_SYNC_FIFO_PACKET_MODE_EN to hold beats until a complete packet (or a full FIFO) is stored.
module axis_sync_fifo #(
    parameter int BYTE_WIDTH = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [8*BYTE_WIDTH-1:0]   s_tdata,
    input  logic [BYTE_WIDTH-1:0]     s_tstrb,
    input  logic [BYTE_WIDTH-1:0]     s_tkeep,
    input  logic                      s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [8*BYTE_WIDTH-1:0]   m_tdata,
    output logic [BYTE_WIDTH-1:0]     m_tstrb,
    output logic [BYTE_WIDTH-1:0]     m_tkeep,
    output logic                      m_tlast,
    output logic [DEPTH_LOG2:0]       level,
    output logic [DEPTH_LOG2:0]       pkt_count
);
    localparam int DW    = 8 * BYTE_WIDTH;
    localparam int EW    = DW + 2 * BYTE_WIDTH + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   pkt_count_q, pkt_count_d;
    logic                  s_tready_q, s_tready_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  push, pop, push_last, pop_last;
    logic [EW-1:0]         head;

    assign push      = s_tvalid && s_tready_q;
    assign pop       = m_tvalid_q && m_tready;
    assign head      = mem_q[rd_ptr_q];
    assign push_last = push && s_tlast;
    assign pop_last  = pop && head[0];

    // The head entry cannot be overwritten while it is presented: writes only
    // happen below full, so the write pointer never aliases a live read pointer.
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast} = head;
    assign s_tready  = s_tready_q;
    assign m_tvalid  = m_tvalid_q;
    assign level     = level_q;
    assign pkt_count = pkt_count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(pop);

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_ONE;
        end else if (pop && !push) begin
            level_d = level_q - CNT_ONE;
        end

        pkt_count_d = pkt_count_q;
        if (push_last && !pop_last) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end else if (pop_last && !push_last) begin
            pkt_count_d = pkt_count_q - CNT_ONE;
        end

        s_tready_d = (level_d < DEPTH_CNT);
`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
        // Releasing a full FIFO without a complete packet avoids deadlock.
        m_tvalid_d = (level_d != '0) && ((pkt_count_d != '0) || (level_d == DEPTH_CNT));
`else
        m_tvalid_d = (level_d != '0);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_count_q <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pkt_count_q <= pkt_count_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tdata, s_tstrb, s_tkeep, s_tlast};
        end
    end
endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo: reset, table-driven fill/drain, packet corners,
// randomized streaming against a queue-based reference model.
module tb_axis_sync_fifo;
    localparam int BW    = 2;
    localparam int DW    = 8 * BW;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
    localparam bit PKT_MODE = 1'b1;
`else
    localparam bit PKT_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic [BW-1:0] s_tstrb, s_tkeep;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [BW-1:0] m_tstrb, m_tkeep;
    logic [DL2:0]  level, pkt_count;

    axis_sync_fifo #(.BYTE_WIDTH(BW), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .level(level), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] strb;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    // Reference model: the stored beats in order, plus the two registered flags.
    beat_t q[$];
    logic  mdl_srdy;
    logic  mdl_mv;
    int    n_vec = 0;
    int    n_err = 0;
    int    n_pop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_pkts();
        int pk = 0;
        foreach (q[i]) if (q[i].last) pk++;
        return pk;
    endfunction

    task automatic check_state();
        int pk;
        pk = model_pkts();
        chk("s_tready", 64'(s_tready), 64'(mdl_srdy));
        chk("m_tvalid", 64'(m_tvalid), 64'(mdl_mv));
        chk("level", 64'(level), 64'(q.size()));
        chk("pkt_count", 64'(pkt_count), 64'(pk));
        if (mdl_mv && q.size() > 0) begin
            chk("head_beat", 64'({m_tdata, m_tstrb, m_tkeep, m_tlast}), 64'(q[0]));
        end
    endtask

    // One clock: capture the handshake the model expects, advance, update and compare.
    task automatic tick();
        logic  push, pop, held;
        beat_t b, snap;
        int    pk;
        push = resetn && s_tvalid && mdl_srdy;
        pop  = resetn && mdl_mv && m_tready;
        held = m_tvalid && !m_tready;
        snap = {m_tdata, m_tstrb, m_tkeep, m_tlast};
        b    = {s_tdata, s_tstrb, s_tkeep, s_tlast};
        @(posedge clk);
        #1;
        if (!resetn) begin
            q.delete();
            mdl_srdy = 1'b0;
            mdl_mv   = 1'b0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (push) q.push_back(b);
            pk       = model_pkts();
            mdl_srdy = (q.size() < DEPTH);
            mdl_mv   = (q.size() != 0) && (!PKT_MODE || pk != 0 || q.size() == DEPTH);
        end
        check_state();
        if (held && resetn) begin
            chk("hold_stable", 64'({m_tdata, m_tstrb, m_tkeep, m_tlast}), 64'(snap));
        end
    endtask

    task automatic drive(input logic sv, input logic [DW-1:0] d, input logic last, input logic mr);
        s_tvalid = sv;
        s_tdata  = d;
        s_tstrb  = '1;
        s_tkeep  = '1;
        s_tlast  = last;
        m_tready = mr;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        repeat (3) tick();
        resetn = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("release_s_tready", 64'(s_tready), 64'd1);
        chk("release_level", 64'(level), 64'd0);
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] d;
        logic          mr;
        int            lvl;
        logic          srdy;
        logic          mv;
        logic [DW-1:0] head;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, cyc;

        q.delete();
        mdl_srdy = 1'b0;
        mdl_mv   = 1'b0;
        resetn   = 1'b0;
        drive(1'b1, 16'h0000, 1'b0, 1'b0);

        // Fill to full with the fifth beat held off, then drain; every beat carries tlast.
        tbl[0] = '{1'b1, 16'h0011, 1'b0, 1, 1'b1, 1'b1, 16'h0011};
        tbl[1] = '{1'b1, 16'h0022, 1'b0, 2, 1'b1, 1'b1, 16'h0011};
        tbl[2] = '{1'b1, 16'h0033, 1'b0, 3, 1'b1, 1'b1, 16'h0011};
        tbl[3] = '{1'b1, 16'h0044, 1'b0, 4, 1'b0, 1'b1, 16'h0011};
        tbl[4] = '{1'b1, 16'h0055, 1'b0, 4, 1'b0, 1'b1, 16'h0011};
        tbl[5] = '{1'b1, 16'h0055, 1'b1, 3, 1'b1, 1'b1, 16'h0022};
        tbl[6] = '{1'b1, 16'h0055, 1'b1, 3, 1'b1, 1'b1, 16'h0033};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 2, 1'b1, 1'b1, 16'h0044};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 1'b1, 16'h0055};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 16'h0000};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].sv, tbl[i].d, 1'b1, tbl[i].mr);
            tick();
            chk("tbl_level", 64'(level), 64'(tbl[i].lvl));
            chk("tbl_pkt_count", 64'(pkt_count), 64'(tbl[i].lvl));
            chk("tbl_s_tready", 64'(s_tready), 64'(tbl[i].srdy));
            chk("tbl_m_tvalid", 64'(m_tvalid), 64'(tbl[i].mv));
            if (tbl[i].mv) chk("tbl_m_tdata", 64'(m_tdata), 64'(tbl[i].head));
        end

        // Packet hold: three beats, tlast only on 0xA3.
        do_reset();
        drive(1'b1, 16'h00A1, 1'b0, 1'b0); tick();
        chk("pkt_a1_m_tvalid", 64'(m_tvalid), PKT_MODE ? 64'd0 : 64'd1);
        drive(1'b1, 16'h00A2, 1'b0, 1'b0); tick();
        chk("pkt_a2_m_tvalid", 64'(m_tvalid), PKT_MODE ? 64'd0 : 64'd1);
        drive(1'b1, 16'h00A3, 1'b1, 1'b0); tick();
        chk("pkt_a3_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("pkt_a3_pkt_count", 64'(pkt_count), 64'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
        tick();
        chk("pkt_head_a3", 64'(m_tdata), 64'h00A3);
        // Push of a tlast beat while the tlast head is popped: count unchanged.
        drive(1'b1, 16'h00B1, 1'b1, 1'b1); tick();
        chk("pkt_simul_pkt_count", 64'(pkt_count), 64'd1);
        chk("pkt_simul_level", 64'(level), 64'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
        chk("pkt_drained_level", 64'(level), 64'd0);

        // Full FIFO with no tlast must still release.
        do_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 16'(16'h00D0 + k), 1'b0, 1'b0);
            tick();
            chk("deadlock_m_tvalid", 64'(m_tvalid), (PKT_MODE && k < DEPTH) ? 64'd0 : 64'd1);
        end
        chk("deadlock_level", 64'(level), 64'(DEPTH));
        chk("deadlock_pkt_count", 64'(pkt_count), 64'd0);

        // Randomized streaming with backpressure.
        do_reset();
        start = n_pop;
        cyc   = 0;
        while ((n_pop - start) < 1000 && cyc < 20000) begin
            s_tvalid = ($urandom_range(0, 9) < 7);
            s_tdata  = 16'($urandom);
            s_tstrb  = 2'($urandom);
            s_tkeep  = 2'($urandom);
            s_tlast  = ($urandom_range(0, 3) == 0);
            m_tready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        chk("random_1000_beats", 64'((n_pop - start) >= 1000), 64'd1);

        // Asynchronous reset with beats in flight.
        drive(1'b1, 16'h0077, 1'b1, 1'b0);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("async_rst_s_tready", 64'(s_tready), 64'd0);
        chk("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_pkt_count", 64'(pkt_count), 64'd0);
        q.delete();
        mdl_srdy = 1'b0;
        mdl_mv   = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("async_release_s_tready", 64'(s_tready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
